// File: rtl/mem_access_ctrl_if.sv
// Bundle of EX/MEM pipeline inputs, data-cache port and MEM/WB outputs for mem_access_ctrl.
// The controller uses the slave view; the surrounding pipeline/cache model uses the master view.
interface mem_access_ctrl_if;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_word;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic [31:0] in_alu_result;
  logic [4:0]  in_dest;
  logic        stall;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [3:0]  dc_be;
  logic [31:0] dc_wdata;
  logic        dc_ready;
  logic        dc_rsp_valid;
  logic [31:0] dc_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  modport slave (
    input  in_valid, in_mem_read, in_mem_write, in_word, in_mem_to_reg, in_reg_write,
    input  in_addr, in_store_data, in_alu_result, in_dest,
    input  dc_ready, dc_rsp_valid, dc_rdata,
    output stall, dc_req, dc_we, dc_addr, dc_be, dc_wdata,
    output wb_valid, wb_reg_write, wb_dest, wb_data, misalign, bus_err
  );

  modport master (
    output in_valid, in_mem_read, in_mem_write, in_word, in_mem_to_reg, in_reg_write,
    output in_addr, in_store_data, in_alu_result, in_dest,
    output dc_ready, dc_rsp_valid, dc_rdata,
    input  stall, dc_req, dc_we, dc_addr, dc_be, dc_wdata,
    input  wb_valid, wb_reg_write, wb_dest, wb_data, misalign, bus_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns loads/stores into data-cache transactions, stalls the
// pipeline while one is outstanding, and drives the registered MEM/WB outputs.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic        r_dcReq;
  logic        r_dcWe;
  logic [31:0] r_dcAddr;
  logic [3:0]  r_dcBe;
  logic [31:0] r_dcWdata;
  logic        r_wbValid;
  logic        r_wbRegWrite;
  logic [4:0]  r_wbDest;
  logic [31:0] r_wbData;
  logic        r_misalign;
  logic        r_busErr;

  logic        w_memOp;
  logic        w_isWrite;
  logic        w_misalign;
  logic        w_rspDone;
  logic        w_timeout;
  logic        w_stall;
  logic [1:0]  w_lane;
  logic [3:0]  w_storeBe;
  logic [31:0] w_storeData;
  logic [7:0]  w_loadByte;
  logic [31:0] w_loadData;

  assign w_lane      = bus.in_addr[1:0];
  assign w_memOp     = bus.in_valid & (bus.in_mem_read | bus.in_mem_write);
  assign w_isWrite   = bus.in_mem_write;
  assign w_misalign  = w_memOp & bus.in_word & (w_lane != 2'b00);
  assign w_storeBe   = (!w_isWrite || bus.in_word) ? 4'hF : (4'b0001 << w_lane);
  assign w_storeData = bus.in_word ? bus.in_store_data : {4{bus.in_store_data[7:0]}};
  assign w_loadByte  = bus.dc_rdata[{w_lane, 3'b000} +: 8];
  assign w_loadData  = bus.in_word ? bus.dc_rdata : {{24{w_loadByte[7]}}, w_loadByte};

  // A response only counts while we are waiting for it; a 0-wait cache answers in REQ with ready.
  assign w_rspDone = bus.dc_rsp_valid &
                     ((r_state == WAIT) | ((r_state == REQ) & bus.dc_ready));
  assign w_timeout = (r_state != IDLE) & (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) & ~w_rspDone;

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memOp && !w_misalign) begin
          w_next  = REQ;
          w_stall = 1'b1;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (w_rspDone || w_timeout) begin
          w_next  = IDLE;
          w_stall = 1'b0;
        end else if (bus.dc_ready) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (w_rspDone || w_timeout) begin
          w_next  = IDLE;
          w_stall = 1'b0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE || w_next == IDLE) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcReq      <= 1'b0;
      r_dcWe       <= 1'b0;
      r_dcAddr     <= '0;
      r_dcBe       <= '0;
      r_dcWdata    <= '0;
      r_wbValid    <= 1'b0;
      r_wbRegWrite <= 1'b0;
      r_wbDest     <= '0;
      r_wbData     <= '0;
      r_misalign   <= 1'b0;
      r_busErr     <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_busErr   <= 1'b0;
      if (r_state == IDLE) begin
        if (w_memOp && !w_misalign) begin
          r_dcReq      <= 1'b1;
          r_dcWe       <= w_isWrite;
          r_dcAddr     <= {bus.in_addr[31:2], 2'b00};
          r_dcBe       <= w_storeBe;
          r_dcWdata    <= w_storeData;
          r_wbValid    <= 1'b0;
          r_wbRegWrite <= 1'b0;
        end else begin
          r_wbValid    <= bus.in_valid;
          r_wbRegWrite <= bus.in_valid & bus.in_reg_write & ~w_misalign;
          r_wbData     <= bus.in_alu_result;
          r_wbDest     <= bus.in_dest;
          r_misalign   <= w_misalign;
        end
      end else if (w_rspDone) begin
        r_dcReq      <= 1'b0;
        r_wbValid    <= 1'b1;
        r_wbRegWrite <= ~w_isWrite & bus.in_reg_write & bus.in_mem_to_reg;
        r_wbData     <= w_isWrite ? bus.in_alu_result : w_loadData;
        r_wbDest     <= bus.in_dest;
      end else if (w_timeout) begin
        r_dcReq      <= 1'b0;
        r_wbValid    <= 1'b1;
        r_wbRegWrite <= 1'b0;
        r_wbDest     <= bus.in_dest;
        r_busErr     <= 1'b1;
      end else begin
        // Stalled: bubble into WB, drop the request once the cache has taken it.
        if (r_state == REQ && bus.dc_ready) r_dcReq <= 1'b0;
        r_wbValid    <= 1'b0;
        r_wbRegWrite <= 1'b0;
      end
    end
  end

  assign bus.stall        = rst_n & w_stall;
  assign bus.dc_req       = r_dcReq;
  assign bus.dc_we        = r_dcWe;
  assign bus.dc_addr      = r_dcAddr;
  assign bus.dc_be        = r_dcBe;
  assign bus.dc_wdata     = r_dcWdata;
  assign bus.wb_valid     = r_wbValid;
  assign bus.wb_reg_write = r_wbRegWrite;
  assign bus.wb_dest      = r_wbDest;
  assign bus.wb_data      = r_wbData;
  assign bus.misalign     = r_misalign;
  assign bus.bus_err      = r_busErr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a scoreboard of expected MEM/WB entries plus
// per-scenario checks of stall timing, cache request fields, misalign and timeout pulses.
module tb_mem_access_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        regWr;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        chkData;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    bus.in_valid      = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_mem_write  = 1'b0;
    bus.in_word       = 1'b0;
    bus.in_mem_to_reg = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_addr       = '0;
    bus.in_store_data = '0;
    bus.in_alu_result = '0;
    bus.in_dest       = '0;
    bus.dc_ready      = 1'b0;
    bus.dc_rsp_valid  = 1'b0;
    bus.dc_rdata      = '0;
  endtask

  // Drives one memory op and plays the cache side; ends #1 after the edge the pipeline advances on.
  task automatic applyStimulus(input logic rd, input logic wr, input logic word,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input logic [4:0] dest,
                               input int readyCyc, input int rspCyc, input int maxCyc,
                               output int stallCyc, output logic reqSeen, output logic capWe,
                               output logic [3:0] capBe, output logic [31:0] capAddr,
                               output logic [31:0] capWdata);
    logic done;
    bus.in_valid      = 1'b1;
    bus.in_mem_read   = rd;
    bus.in_mem_write  = wr;
    bus.in_word       = word;
    bus.in_mem_to_reg = rd;
    bus.in_reg_write  = rd;
    bus.in_addr       = addr;
    bus.in_store_data = sdata;
    bus.in_alu_result = addr;
    bus.in_dest       = dest;
    stallCyc = 0;
    reqSeen  = 1'b0;
    capWe    = 1'b0;
    capBe    = '0;
    capAddr  = '0;
    capWdata = '0;
    for (int c = 0; c < maxCyc; c++) begin
      bus.dc_ready     = (c == readyCyc);
      bus.dc_rsp_valid = (c == rspCyc);
      bus.dc_rdata     = (c == rspCyc) ? rdata : 32'h0;
      @(negedge clk);
      if (bus.stall) stallCyc++;
      if (bus.dc_req && !reqSeen) begin
        reqSeen  = 1'b1;
        capWe    = bus.dc_we;
        capBe    = bus.dc_be;
        capAddr  = bus.dc_addr;
        capWdata = bus.dc_wdata;
      end
      done = !bus.stall;
      tick();
      if (done) break;
    end
    idleInputs();
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    idleInputs();
    #2 rst_n = 1'b0;
    #2;
    compared++;
    if ({bus.stall, bus.dc_req, bus.dc_we, bus.dc_addr, bus.dc_be, bus.dc_wdata, bus.wb_valid,
         bus.wb_reg_write, bus.wb_dest, bus.wb_data, bus.misalign, bus.bus_err} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got dc_req=%b wb_valid=%b dc_addr=%h wb_data=%h want all 0",
               bus.dc_req, bus.wb_valid, bus.dc_addr, bus.wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    logic [31:0] alu  [2] = '{32'h0000_0005, 32'h0000_0077};
    logic [4:0]  dst  [2] = '{5'd3, 5'd9};
    logic        rw   [2] = '{1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid      = 1'b1;
      bus.in_reg_write  = rw[i];
      bus.in_alu_result = alu[i];
      bus.in_dest       = dst[i];
      sbq.push_back('{rw[i], dst[i], alu[i], 1'b1});
      @(negedge clk);
      compared++;
      if (bus.stall !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL pass_stall%0d: got %b want 0", i, bus.stall);
      end
      tick();
      idleInputs();
      compared++;
      if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL pass_wb_valid%0d: got %b want 1", i, bus.wb_valid);
      end else begin
        e = sbq.pop_front();
        compared += 3;
        if (bus.wb_reg_write !== e.regWr) begin
          mismatched++;
          $display("[TB] FAIL pass_reg_write%0d: got %b want %b", i, bus.wb_reg_write, e.regWr);
        end
        if (bus.wb_dest !== e.dest) begin
          mismatched++;
          $display("[TB] FAIL pass_dest%0d: got %0d want %0d", i, bus.wb_dest, e.dest);
        end
        if (bus.wb_data !== e.data) begin
          mismatched++;
          $display("[TB] FAIL pass_data%0d: got %h want %h", i, bus.wb_data, e.data);
        end
      end
    end
    tick();
    compared++;
    if (bus.wb_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bubble_wb_valid: got %b want 0", bus.wb_valid);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        word;
    logic [31:0] rdata;
    logic [31:0] expData;
    logic [31:0] dcAddr;
    int          readyCyc;
    int          rspCyc;
    int          stalls;
  } ld_t;

  task automatic test_loads;
    ld_t  lt [3];
    exp_t e;
    int   s;
    logic rq, we;
    logic [3:0]  be;
    logic [31:0] a, wd;
    lt[0] = '{32'h100, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 2, 4, 4};
    lt[1] = '{32'h203, 1'b0, 32'h8012_3456, 32'hFFFF_FF80, 32'h200, 1, 2, 2};
    lt[2] = '{32'h201, 1'b0, 32'h8012_3456, 32'h0000_0034, 32'h200, 1, 2, 2};
    for (int i = 0; i < 3; i++) begin
      sbq.push_back('{1'b1, 5'(i + 4), lt[i].expData, 1'b1});
      applyStimulus(1'b1, 1'b0, lt[i].word, lt[i].addr, 32'h0, lt[i].rdata, 5'(i + 4),
                    lt[i].readyCyc, lt[i].rspCyc, 20, s, rq, we, be, a, wd);
      compared += 4;
      if (s !== lt[i].stalls) begin
        mismatched++;
        $display("[TB] FAIL load%0d_stall_cycles: got %0d want %0d", i, s, lt[i].stalls);
      end
      if (rq !== 1'b1 || a !== lt[i].dcAddr) begin
        mismatched++;
        $display("[TB] FAIL load%0d_dc_addr: got req=%b addr=%h want req=1 addr=%h", i, rq, a, lt[i].dcAddr);
      end
      if (be !== 4'hF || we !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL load%0d_be_we: got be=%h we=%b want be=f we=0", i, be, we);
      end
      if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL load%0d_wb_valid: got %b want 1", i, bus.wb_valid);
      end else begin
        e = sbq.pop_front();
        compared += 3;
        if (bus.wb_reg_write !== e.regWr) begin
          mismatched++;
          $display("[TB] FAIL load%0d_reg_write: got %b want %b", i, bus.wb_reg_write, e.regWr);
        end
        if (bus.wb_dest !== e.dest) begin
          mismatched++;
          $display("[TB] FAIL load%0d_dest: got %0d want %0d", i, bus.wb_dest, e.dest);
        end
        if (bus.wb_data !== e.data) begin
          mismatched++;
          $display("[TB] FAIL load%0d_data: got %h want %h", i, bus.wb_data, e.data);
        end
      end
    end
  endtask

  // Byte store with a slow ack, then a word store against a 0-wait cache.
  task automatic test_stores;
    logic [31:0] addr [2] = '{32'h102, 32'h010};
    logic [31:0] sd   [2] = '{32'h1234_56AB, 32'hCAFE_F00D};
    logic        wrd  [2] = '{1'b0, 1'b1};
    int          rdy  [2] = '{1, 1};
    int          rsp  [2] = '{3, 1};
    int          stl  [2] = '{3, 1};
    logic [3:0]  xBe  [2] = '{4'b0100, 4'hF};
    logic [31:0] xWd  [2] = '{32'hABAB_ABAB, 32'hCAFE_F00D};
    logic [31:0] xA   [2] = '{32'h100, 32'h010};
    exp_t e;
    int   s;
    logic rq, we;
    logic [3:0]  be;
    logic [31:0] a, wd;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back('{1'b0, 5'(i + 12), 32'h0, 1'b0});
      applyStimulus(1'b0, 1'b1, wrd[i], addr[i], sd[i], 32'h0, 5'(i + 12),
                    rdy[i], rsp[i], 20, s, rq, we, be, a, wd);
      compared += 3;
      if (s !== stl[i]) begin
        mismatched++;
        $display("[TB] FAIL store%0d_stall_cycles: got %0d want %0d", i, s, stl[i]);
      end
      if (rq !== 1'b1 || we !== 1'b1 || a !== xA[i]) begin
        mismatched++;
        $display("[TB] FAIL store%0d_req: got req=%b we=%b addr=%h want 1 1 %h", i, rq, we, a, xA[i]);
      end
      if (be !== xBe[i] || wd !== xWd[i]) begin
        mismatched++;
        $display("[TB] FAIL store%0d_be_wdata: got %b %h want %b %h", i, be, wd, xBe[i], xWd[i]);
      end
      compared++;
      if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL store%0d_wb_valid: got %b want 1", i, bus.wb_valid);
      end else begin
        e = sbq.pop_front();
        compared += 2;
        if (bus.wb_reg_write !== e.regWr) begin
          mismatched++;
          $display("[TB] FAIL store%0d_reg_write: got %b want %b", i, bus.wb_reg_write, e.regWr);
        end
        if (bus.wb_dest !== e.dest) begin
          mismatched++;
          $display("[TB] FAIL store%0d_dest: got %0d want %0d", i, bus.wb_dest, e.dest);
        end
      end
    end
  endtask

  task automatic test_misalign;
    exp_t e;
    int   s;
    logic rq, we;
    logic [3:0]  be;
    logic [31:0] a, wd;
    sbq.push_back('{1'b0, 5'd20, 32'h0, 1'b0});
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h006, 32'h5555_5555, 32'h0, 5'd20,
                  1, 2, 6, s, rq, we, be, a, wd);
    compared += 3;
    if (s !== 0) begin
      mismatched++;
      $display("[TB] FAIL misalign_stall: got %0d want 0", s);
    end
    if (rq !== 1'b0 || bus.dc_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misalign_no_req: got %b/%b want 0", rq, bus.dc_req);
    end
    if (bus.misalign !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL misalign_pulse: got %b want 1", bus.misalign);
    end
    compared++;
    if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL misalign_wb_valid: got %b want 1", bus.wb_valid);
    end else begin
      e = sbq.pop_front();
      compared++;
      if (bus.wb_reg_write !== e.regWr || bus.wb_dest !== e.dest) begin
        mismatched++;
        $display("[TB] FAIL misalign_wb: got rw=%b dest=%0d want rw=%b dest=%0d",
                 bus.wb_reg_write, bus.wb_dest, e.regWr, e.dest);
      end
    end
    tick();
    compared++;
    if (bus.misalign !== 1'b0 || bus.dc_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL misalign_one_cycle: got misalign=%b dc_req=%b want 0 0", bus.misalign, bus.dc_req);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    int   s;
    logic rq, we;
    logic [3:0]  be;
    logic [31:0] a, wd;
    sbq.push_back('{1'b0, 5'd21, 32'h0, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h040, 32'h0, 32'h0, 5'd21,
                  1, -1, 30, s, rq, we, be, a, wd);
    compared += 2;
    if (s !== TO) begin
      mismatched++;
      $display("[TB] FAIL timeout_stall_cycles: got %0d want %0d", s, TO);
    end
    if (bus.bus_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL timeout_bus_err: got %b want 1", bus.bus_err);
    end
    compared++;
    if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL timeout_wb_valid: got %b want 1", bus.wb_valid);
    end else begin
      e = sbq.pop_front();
      compared++;
      if (bus.wb_reg_write !== e.regWr || bus.wb_dest !== e.dest) begin
        mismatched++;
        $display("[TB] FAIL timeout_wb: got rw=%b dest=%0d want rw=%b dest=%0d",
                 bus.wb_reg_write, bus.wb_dest, e.regWr, e.dest);
      end
    end
    // A response arriving after the timeout must be ignored.
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rdata     = 32'h1111_2222;
    @(negedge clk);
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL late_rsp_stall: got %b want 0", bus.stall);
    end
    tick();
    idleInputs();
    compared++;
    if (bus.bus_err !== 1'b0 || bus.wb_valid !== 1'b0 || bus.dc_req !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL late_rsp_ignored: got bus_err=%b wb_valid=%b dc_req=%b want 0 0 0",
               bus.bus_err, bus.wb_valid, bus.dc_req);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bus.in_valid      = 1'b1;
    bus.in_mem_read   = 1'b1;
    bus.in_word       = 1'b1;
    bus.in_mem_to_reg = 1'b1;
    bus.in_reg_write  = 1'b1;
    bus.in_addr       = 32'h040;
    bus.in_dest       = 5'd22;
    tick();
    bus.dc_ready = 1'b1;
    tick();
    bus.dc_ready = 1'b0;
    #1;
    compared++;
    if (bus.stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wait_stall: got %b want 1", bus.stall);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.stall !== 1'b0 || bus.dc_req !== 1'b0 || bus.wb_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid: got stall=%b dc_req=%b wb_valid=%b want 0 0 0",
               bus.stall, bus.dc_req, bus.wb_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idleInputs();
    bus.dc_rsp_valid = 1'b1;
    bus.dc_rdata     = 32'hBAD0_BAD0;
    tick();
    bus.dc_rsp_valid = 1'b0;
    compared++;
    if (bus.wb_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_rsp_ignored: got wb_valid=%b want 0", bus.wb_valid);
    end
    bus.in_valid      = 1'b1;
    bus.in_reg_write  = 1'b1;
    bus.in_alu_result = 32'h0000_0042;
    bus.in_dest       = 5'd23;
    sbq.push_back('{1'b1, 5'd23, 32'h0000_0042, 1'b1});
    tick();
    idleInputs();
    compared++;
    if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_wb_valid: got %b want 1", bus.wb_valid);
    end else begin
      e = sbq.pop_front();
      compared++;
      if (bus.wb_data !== e.data || bus.wb_dest !== e.dest) begin
        mismatched++;
        $display("[TB] FAIL post_reset_wb: got %h/%0d want %h/%0d", bus.wb_data, bus.wb_dest, e.data, e.dest);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid();
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries left want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
